// File: rtl/iwdg_wb.sv
// ---------------------------------------------------------------------------
// iwdg_wb -- independent watchdog with a Wishbone classic slave interface.
//
// A 12-bit down-counter is decremented once every "divider" ticks of the
// low-speed oscillator (LSI). If software lets it run past zero, rst_iwdg is
// pulsed for one clock and the counter reloads. Software refreshes it
// through the key register. Everything runs on clk_m2s. clk_lsi is only
// sampled as a data level.
//
// Ports
//   clk_m2s   : bus clock, the only clock in the design
//   rst_m2s   : synchronous active-high reset
//   clk_lsi   : LSI oscillator level (asynchronous, synchronized here)
//   dat_m2s   : write data
//   adr_m2s   : byte address, must exactly match one register address
//   sel_m2s   : byte selects (ignored, all writes are full width)
//   cyc_m2s   : bus cycle valid
//   we_m2s    : 1 = write, 0 = read
//   lok_m2s   : bus lock (ignored)
//   stb_m2s   : strobe
//   err_s2m   : error termination for unmapped addresses
//   rty_s2m   : retry, never used (tied low)
//   dat_s2m   : read data, valid with ack_s2m and zero otherwise
//   ack_s2m   : acknowledge, one cycle after the request
//   rst_iwdg  : one-cycle watchdog reset pulse
// ---------------------------------------------------------------------------
module iwdg_wb #(
  parameter int          GRL           = 1,
  parameter int          IWDG_KR_SIZE  = 16,
  parameter int          IWDG_PR_SIZE  = 3,
  parameter int          IWDG_RLR_SIZE = 12,
  parameter int          IWDG_ST_SIZE  = 2,
  parameter logic [31:0] BASE_ADR      = 32'h0100_0000,
  parameter logic [31:0] IWDG_KR_ADR   = BASE_ADR + 32'h0,
  parameter logic [31:0] IWDG_PR_ADR   = BASE_ADR + 32'h4,
  parameter logic [31:0] IWDG_RLR_ADR  = BASE_ADR + 32'h8,
  parameter logic [31:0] IWDG_ST_ADR   = BASE_ADR + 32'hC
) (
  input  logic         clk_m2s,
  input  logic         rst_m2s,
  input  logic         clk_lsi,
  input  logic [31:0]  dat_m2s,
  input  logic [31:0]  adr_m2s,
  input  logic [GRL:0] sel_m2s,
  input  logic         cyc_m2s,
  input  logic         we_m2s,
  input  logic         lok_m2s,
  input  logic         stb_m2s,
  output logic         err_s2m,
  output logic         rty_s2m,
  output logic [31:0]  dat_s2m,
  output logic         ack_s2m,
  output logic         rst_iwdg
);

  localparam logic [IWDG_KR_SIZE-1:0] KEY_ENABLE = IWDG_KR_SIZE'(16'hCCCC);
  localparam logic [IWDG_KR_SIZE-1:0] KEY_RELOAD = IWDG_KR_SIZE'(16'hAAAA);
  localparam logic [IWDG_KR_SIZE-1:0] KEY_UNLOCK = IWDG_KR_SIZE'(16'h5555);

  // LSI synchronizer / edge detector
  logic [1:0] r_lsiSync;
  logic       r_lsiDly;
  logic       w_tick;

  // bus response
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_dat;

  // programming registers and their shadows
  logic [IWDG_PR_SIZE-1:0]  r_pr;
  logic [IWDG_PR_SIZE-1:0]  r_prShadow;
  logic                     r_pvu;
  logic [IWDG_RLR_SIZE-1:0] r_rlr;
  logic [IWDG_RLR_SIZE-1:0] r_rlrShadow;
  logic                     r_rvu;
  logic                     r_enabled;
  logic                     r_writeAccess;

  // countdown machinery
  logic [IWDG_RLR_SIZE-1:0] r_cnt;
  logic [7:0]               r_psc;
  logic                     r_rstIwdg;

  // decoded bus signals
  logic                    w_req;
  logic                    w_hitKr;
  logic                    w_hitPr;
  logic                    w_hitRlr;
  logic                    w_hitSt;
  logic                    w_hit;
  logic                    w_wrKr;
  logic                    w_prAccept;
  logic                    w_rlrAccept;
  logic                    w_keyReload;
  logic [IWDG_KR_SIZE-1:0] w_key;
  logic [IWDG_ST_SIZE-1:0] w_status;
  logic [31:0]             w_rdata;

  // divider arithmetic
  logic [IWDG_PR_SIZE-1:0] w_prClamp;
  logic [8:0]              w_div;
  logic [7:0]              w_divM1;
  logic                    w_pscWrap;

  // Upper data bits, byte selects and lock carry no meaning for this block.
  logic w_unused;
  assign w_unused = ^{sel_m2s, lok_m2s, dat_m2s[31:IWDG_KR_SIZE]};

  // clk_lsi is asynchronous to the bus clock: two flops bring it into the
  // clk_m2s domain, and a third copy lets us spot the rising edge. The tick
  // is high for exactly one bus cycle per LSI period.
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      r_lsiSync <= 2'b00;
      r_lsiDly  <= 1'b0;
    end else begin
      r_lsiSync <= {r_lsiSync[0], clk_lsi};
      r_lsiDly  <= r_lsiSync[1];
    end
  end

  assign w_tick = r_lsiSync[1] & ~r_lsiDly;

  // A new request is only recognised while no termination is being driven,
  // so a master holding stb across the ack cycle does not get a double hit.
  assign w_req    = stb_m2s & cyc_m2s & ~r_ack & ~r_err;
  assign w_hitKr  = (adr_m2s == IWDG_KR_ADR);
  assign w_hitPr  = (adr_m2s == IWDG_PR_ADR);
  assign w_hitRlr = (adr_m2s == IWDG_RLR_ADR);
  assign w_hitSt  = (adr_m2s == IWDG_ST_ADR);
  assign w_hit    = w_hitKr | w_hitPr | w_hitRlr | w_hitSt;

  assign w_key       = dat_m2s[IWDG_KR_SIZE-1:0];
  assign w_wrKr      = w_req & we_m2s & w_hitKr;
  assign w_prAccept  = w_req & we_m2s & w_hitPr & r_writeAccess;
  assign w_rlrAccept = w_req & we_m2s & w_hitRlr & r_writeAccess;

  // The enable key only restarts the count the first time; once running,
  // only the reload key (or a timeout) puts RLR back into the counter.
  assign w_keyReload = w_wrKr & ((w_key == KEY_RELOAD) |
                                 ((w_key == KEY_ENABLE) & ~r_enabled));

  assign w_status = {r_rvu, r_pvu};

  // Read mux. KR is write-only and reads back as zero.
  always_comb begin
    w_rdata = 32'h0;
    if (w_hitPr) begin
      w_rdata = {{(32-IWDG_PR_SIZE){1'b0}}, r_pr};
    end else if (w_hitRlr) begin
      w_rdata = {{(32-IWDG_RLR_SIZE){1'b0}}, r_rlr};
    end else if (w_hitSt) begin
      w_rdata = {{(32-IWDG_ST_SIZE){1'b0}}, w_status};
    end
  end

  // Single-cycle Wishbone termination. Read data is only presented
  // alongside ack; every other cycle the data bus is driven to zero.
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_req & w_hit;
      r_err <= w_req & ~w_hit;
      r_dat <= (w_req & w_hit & ~we_m2s) ? w_rdata : 32'h0;
    end
  end

  // Key register: enable is sticky until bus reset, and write access is
  // re-evaluated on every key write (any non-unlock key locks PR/RLR again).
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      r_enabled     <= 1'b0;
      r_writeAccess <= 1'b0;
    end else if (w_wrKr) begin
      r_writeAccess <= (w_key == KEY_UNLOCK);
      if (w_key == KEY_ENABLE) begin
        r_enabled <= 1'b1;
      end
    end
  end

  // PR: a write lands in the shadow and raises PVU; the active value only
  // changes on the next LSI tick. A fresh write in the same cycle as a
  // tick wins, keeping PVU set so the newest value is the one applied.
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      r_pr       <= '0;
      r_prShadow <= '0;
      r_pvu      <= 1'b0;
    end else if (w_prAccept) begin
      r_prShadow <= dat_m2s[IWDG_PR_SIZE-1:0];
      r_pvu      <= 1'b1;
    end else if (w_tick & r_pvu) begin
      r_pr  <= r_prShadow;
      r_pvu <= 1'b0;
    end
  end

  // RLR follows the same shadow/tick update scheme as PR.
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      r_rlr       <= '1;
      r_rlrShadow <= '1;
      r_rvu       <= 1'b0;
    end else if (w_rlrAccept) begin
      r_rlrShadow <= dat_m2s[IWDG_RLR_SIZE-1:0];
      r_rvu       <= 1'b1;
    end else if (w_tick & r_rvu) begin
      r_rlr <= r_rlrShadow;
      r_rvu <= 1'b0;
    end
  end

  // Divider is 4 << PR, saturating at 256 for PR >= 6.
  assign w_prClamp = (r_pr > IWDG_PR_SIZE'(6)) ? IWDG_PR_SIZE'(6) : r_pr;
  assign w_div     = 9'd4 << w_prClamp;
  assign w_divM1   = 8'(w_div - 9'd1);
  // ">=" rather than "==" so that shrinking PR mid-count cannot strand the
  // prescaler above the new terminal value.
  assign w_pscWrap = (r_psc >= w_divM1);

  // Prescaler and down-counter. A key reload in the same cycle as a count
  // event takes priority, so the refresh always wins the race and no reset
  // pulse is produced.
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      r_cnt     <= '1;
      r_psc     <= 8'd0;
      r_rstIwdg <= 1'b0;
    end else begin
      r_rstIwdg <= 1'b0;
      if (w_keyReload) begin
        r_cnt <= r_rlr;
        r_psc <= 8'd0;
      end else if (r_enabled & w_tick) begin
        if (w_pscWrap) begin
          r_psc <= 8'd0;
          if (r_cnt == '0) begin
            r_rstIwdg <= 1'b1;
            r_cnt     <= r_rlr;
          end else begin
            r_cnt <= r_cnt - IWDG_RLR_SIZE'(1);
          end
        end else begin
          r_psc <= r_psc + 8'd1;
        end
      end
    end
  end

  assign ack_s2m  = r_ack;
  assign err_s2m  = r_err;
  assign rty_s2m  = 1'b0;
  assign dat_s2m  = r_dat;
  assign rst_iwdg = r_rstIwdg;

endmodule

// File: tb/tb_iwdg_wb.sv
// ---------------------------------------------------------------------------
// tb_iwdg_wb -- self-checking bench for iwdg_wb.
//
// A behavioural model of the watchdog (register file, key semantics,
// tick-driven timeout arithmetic) is advanced on every bus clock and every
// DUT output is compared with it on the falling edge. Directed scenarios
// add hand-computed expectations (reset values, timeout lengths measured in
// LSI rising edges, lock behaviour, bad addresses), followed by a stretch of
// randomized bus traffic.
// ---------------------------------------------------------------------------
module tb_iwdg_wb;

  localparam logic [31:0] KR_A   = 32'h0100_0000;
  localparam logic [31:0] PR_A   = 32'h0100_0004;
  localparam logic [31:0] RLR_A  = 32'h0100_0008;
  localparam logic [31:0] ST_A   = 32'h0100_000C;
  localparam logic [31:0] BAD_A  = 32'h0100_0010;

  logic        clk;
  logic        rstM2s;
  logic        clkLsi;
  logic [31:0] datM2s;
  logic [31:0] adrM2s;
  logic [1:0]  selM2s;
  logic        cycM2s;
  logic        weM2s;
  logic        lokM2s;
  logic        stbM2s;
  logic        errS2m;
  logic        rtyS2m;
  logic [31:0] datS2m;
  logic        ackS2m;
  logic        rstIwdg;

  int nAssert = 0;
  int nFail   = 0;
  int rstSeen = 0;
  int lsiRises;
  bit lsiHold = 1'b0;
  bit checkOn = 1'b0;
  bit done    = 1'b0;

  // behavioural model state
  logic        mAck, mErr, mRst;
  logic [31:0] mDat;
  logic [2:0]  mPr, mPrSh;
  logic [11:0] mRlr, mRlrSh;
  logic        mPvu, mRvu, mEn, mWa;
  int          mCnt, mPsc;
  logic [2:0]  lsiHist;

  iwdg_wb dut (
    .clk_m2s (clk),
    .rst_m2s (rstM2s),
    .clk_lsi (clkLsi),
    .dat_m2s (datM2s),
    .adr_m2s (adrM2s),
    .sel_m2s (selM2s),
    .cyc_m2s (cycM2s),
    .we_m2s  (weM2s),
    .lok_m2s (lokM2s),
    .stb_m2s (stbM2s),
    .err_s2m (errS2m),
    .rty_s2m (rtyS2m),
    .dat_s2m (datS2m),
    .ack_s2m (ackS2m),
    .rst_iwdg(rstIwdg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LSI source: each phase lasts 3..5 bus cycles. While lsiHold is set the
  // level is parked low so no tick can be in flight.
  initial begin
    clkLsi   = 1'b0;
    lsiRises = 0;
    forever begin
      repeat ($urandom_range(3, 5)) @(negedge clk);
      if (!lsiHold || clkLsi) begin
        clkLsi = ~clkLsi;
        if (clkLsi) lsiRises++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nAssert++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  // One bus clock of the reference model. A tick reaches the watchdog two
  // clocks after the clock that first sampled clk_lsi high.
  task automatic modelStep();
    logic        tick, req, hit, kReload, oldEn, oldWa;
    logic [11:0] oldRlr;
    logic [31:0] rd;
    logic [15:0] key;
    int          div;
    tick    = lsiHist[1] && !lsiHist[2];
    lsiHist = {lsiHist[1:0], clkLsi};
    if (rstM2s) begin
      mAck = 0; mErr = 0; mRst = 0; mDat = 0;
      mPr = 0; mPrSh = 0; mPvu = 0;
      mRlr = 12'hFFF; mRlrSh = 12'hFFF; mRvu = 0;
      mEn = 0; mWa = 0; mCnt = 'hFFF; mPsc = 0;
      lsiHist = 3'b000;
      return;
    end
    req = stbM2s && cycM2s && !mAck && !mErr;
    hit = adrM2s inside {KR_A, PR_A, RLR_A, ST_A};
    case (adrM2s)
      PR_A:    rd = {29'b0, mPr};
      RLR_A:   rd = {20'b0, mRlr};
      ST_A:    rd = {30'b0, mRvu, mPvu};
      default: rd = 32'h0;
    endcase
    div    = 4 << ((mPr > 3'd6) ? 6 : int'(mPr));
    oldRlr = mRlr;
    oldEn  = mEn;
    oldWa  = mWa;
    kReload = 0;
    if (req && hit && weM2s && adrM2s == KR_A) begin
      key = datM2s[15:0];
      if (key == 16'hAAAA) kReload = 1;
      if (key == 16'hCCCC) begin
        if (!oldEn) kReload = 1;
        mEn = 1;
      end
      mWa = (key == 16'h5555);
    end
    if (req && hit && weM2s && adrM2s == PR_A && oldWa) begin
      mPrSh = datM2s[2:0]; mPvu = 1;
    end else if (tick && mPvu) begin
      mPr = mPrSh; mPvu = 0;
    end
    if (req && hit && weM2s && adrM2s == RLR_A && oldWa) begin
      mRlrSh = datM2s[11:0]; mRvu = 1;
    end else if (tick && mRvu) begin
      mRlr = mRlrSh; mRvu = 0;
    end
    mRst = 0;
    if (kReload) begin
      mCnt = int'(oldRlr);
      mPsc = 0;
    end else if (oldEn && tick) begin
      mPsc++;
      if (mPsc >= div) begin
        mPsc = 0;
        if (mCnt == 0) begin
          mRst = 1;
          mCnt = int'(oldRlr);
        end else begin
          mCnt--;
        end
      end
    end
    mAck = req && hit;
    mErr = req && !hit;
    mDat = (req && hit && !weM2s) ? rd : 32'h0;
  endtask

  // One bus transaction: request on one clock, termination sampled on the
  // falling edge of the next.
  task automatic applyStimulus(input bit we, input logic [31:0] adr,
                               input logic [31:0] dat, output logic [31:0] rdat,
                               output bit gotAck, output bit gotErr);
    @(negedge clk);
    cycM2s = 1'b1; stbM2s = 1'b1; weM2s = we; adrM2s = adr; datM2s = dat;
    @(negedge clk);
    rdat = datS2m; gotAck = ackS2m; gotErr = errS2m;
    cycM2s = 1'b0; stbM2s = 1'b0; weM2s = 1'b0;
  endtask

  task automatic readReg(input logic [31:0] adr, input logic [31:0] expv,
                         input string name);
    logic [31:0] rd;
    bit a, e;
    applyStimulus(1'b0, adr, 32'h0, rd, a, e);
    checkOutput({name, " ack"}, 64'(a), 64'(1));
    checkOutput({name, " data"}, 64'(rd), 64'(expv));
  endtask

  task automatic writeReg(input logic [31:0] adr, input logic [31:0] dat,
                          input string name);
    logic [31:0] rd;
    bit a, e;
    applyStimulus(1'b1, adr, dat, rd, a, e);
    checkOutput({name, " ack"}, 64'({a, e}), 64'(2'b10));
  endtask

  task automatic flushLsi();
    lsiHold = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic waitPulse(input int maxCycles, input string name, output int risesAt);
    bit seen;
    seen    = 1'b0;
    risesAt = -1;
    for (int c = 0; c < maxCycles && !seen; c++) begin
      @(negedge clk);
      if (rstIwdg) begin
        seen    = 1'b1;
        risesAt = lsiRises;
      end
    end
    checkOutput({name, " seen"}, 64'(seen), 64'(1));
  endtask

  task automatic waitRises(input int n, input string name);
    int target;
    bit ok;
    target = lsiRises + n;
    ok     = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (lsiRises >= target) ok = 1'b1;
    end
    checkOutput({name, " reached"}, 64'(ok), 64'(1));
  endtask

  initial begin
    int base, at1, at2, p0, startR, last;
    logic [31:0] rd;
    bit a, e;
    rstM2s = 1'b1; datM2s = 0; adrM2s = 0; selM2s = 2'b11;
    cycM2s = 0; weM2s = 0; lokM2s = 0; stbM2s = 0;
    mAck = 0; mErr = 0; mRst = 0; mDat = 0; lsiHist = 0;
    fork
      begin
        while (!done) begin
          @(posedge clk);
          modelStep();
          @(negedge clk);
          if (checkOn) begin
            checkOutput("cycle outputs {ack,err,rst_iwdg,rty,dat}",
                        64'({ackS2m, errS2m, rstIwdg, rtyS2m, datS2m}),
                        64'({mAck, mErr, mRst, 1'b0, mDat}));
            if (rstIwdg) rstSeen++;
          end
        end
      end
      begin
        repeat (3) @(negedge clk);
        rstM2s  = 1'b0;
        checkOn = 1'b1;
        $display("[TB] reset released");

        checkOutput("rst_iwdg after reset", 64'(rstIwdg), 64'(0));
        readReg(KR_A,  32'h0,   "KR after reset");
        readReg(RLR_A, 32'hFFF, "RLR after reset");
        readReg(PR_A,  32'h0,   "PR after reset");
        readReg(ST_A,  32'h0,   "SR after reset");

        writeReg(RLR_A, 32'h5, "locked RLR write");
        readReg(RLR_A, 32'hFFF, "RLR after locked write");
        readReg(ST_A,  32'h0,   "SR after locked write");

        $display("[TB] unlock and program PR=0 RLR=3");
        flushLsi();
        writeReg(KR_A,  32'h5555, "KR unlock");
        writeReg(PR_A,  32'h0,    "PR write");
        writeReg(RLR_A, 32'h3,    "RLR write");
        readReg(ST_A,  32'h3,   "SR pending");
        readReg(RLR_A, 32'hFFF, "RLR before tick");
        lsiHold = 1'b0;
        waitRises(1, "first tick");
        repeat (4) @(negedge clk);
        readReg(ST_A,  32'h0, "SR after tick");
        readReg(RLR_A, 32'h3, "RLR after tick");
        checkOutput("model RLR after tick", 64'(mRlr), 64'(3));

        $display("[TB] enable, expect timeout every 16 ticks");
        flushLsi();
        writeReg(KR_A, 32'hCCCC, "KR enable");
        checkOutput("model counter after enable", 64'(mCnt), 64'(3));
        lsiHold = 1'b0;
        base    = lsiRises;
        waitPulse(400, "first timeout", at1);
        checkOutput("ticks to first timeout", 64'(at1 - base), 64'(16));
        waitPulse(400, "second timeout", at2);
        checkOutput("ticks between timeouts", 64'(at2 - at1), 64'(16));

        $display("[TB] refresh every 8 ticks");
        repeat (2) @(negedge clk);
        p0     = rstSeen;
        startR = lsiRises;
        last   = lsiRises;
        for (int c = 0; c < 2000 && (lsiRises - startR) < 120; c++) begin
          if (lsiRises - last >= 8) begin
            last = lsiRises;
            writeReg(KR_A, 32'hAAAA, "KR refresh");
          end else begin
            @(negedge clk);
          end
        end
        repeat (2) @(negedge clk);
        checkOutput("pulses while refreshed", 64'(rstSeen - p0), 64'(0));
        waitPulse(400, "timeout after refresh stops", at1);

        $display("[TB] reload, then second enable must not restart count");
        flushLsi();
        writeReg(KR_A, 32'hAAAA, "KR reload");
        lsiHold = 1'b0;
        base    = lsiRises;
        waitRises(4, "four ticks");
        writeReg(KR_A, 32'hCCCC, "KR second enable");
        waitPulse(400, "timeout after second enable", at1);
        checkOutput("ticks from reload to timeout", 64'(at1 - base), 64'(16));

        $display("[TB] unmapped address");
        applyStimulus(1'b0, BAD_A, 32'h0, rd, a, e);
        checkOutput("bad read {ack,err}", 64'({a, e}), 64'(2'b01));
        checkOutput("bad read data", 64'(rd), 64'(0));
        writeReg(KR_A, 32'h5555, "KR unlock again");
        applyStimulus(1'b1, BAD_A, 32'h5, rd, a, e);
        checkOutput("bad write {ack,err}", 64'({a, e}), 64'(2'b01));
        readReg(RLR_A, 32'h3, "RLR after bad write");
        readReg(ST_A,  32'h0, "SR after bad write");
        writeReg(KR_A, 32'h0, "KR relock");

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
          @(negedge clk);
          rstM2s = ($urandom_range(0, 999) == 0);
          stbM2s = ($urandom_range(0, 2) != 0);
          cycM2s = stbM2s ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1);
          weM2s  = ($urandom_range(0, 1) == 1);
          selM2s = 2'($urandom_range(0, 3));
          lokM2s = ($urandom_range(0, 1) == 1);
          case ($urandom_range(0, 4))
            0:       adrM2s = KR_A;
            1:       adrM2s = PR_A;
            2:       adrM2s = RLR_A;
            3:       adrM2s = ST_A;
            default: adrM2s = ($urandom_range(0, 1) == 1) ? BAD_A : $urandom;
          endcase
          case ($urandom_range(0, 6))
            0:       datM2s = 32'h5555;
            1:       datM2s = 32'hAAAA;
            2:       datM2s = 32'hCCCC;
            3:       datM2s = $urandom;
            default: datM2s = $urandom_range(0, 15);
          endcase
        end
        @(negedge clk);
        rstM2s = 1'b0; stbM2s = 1'b0; cycM2s = 1'b0; weM2s = 1'b0; lokM2s = 1'b0;

        rstM2s = 1'b1;
        repeat (2) @(negedge clk);
        rstM2s = 1'b0;
        readReg(RLR_A, 32'hFFF, "RLR after final reset");
        readReg(PR_A,  32'h0,   "PR after final reset");
        readReg(ST_A,  32'h0,   "SR after final reset");
        done = 1'b1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
